// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: LC-3b word/opcode types, queue entry layout and control-flow predecode
package instr_queue_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_trap = 4'b1111;
  typedef struct packed {
    lc3b_word ir;
    lc3b_word pc;
    logic     is_cf;
  } iq_entry_t;
  function automatic logic is_control_flow(input lc3b_opcode op);
    return (op == op_br) || (op == op_jmp) || (op == op_jsr) || (op == op_trap);
  endfunction
endpackage

// File: rtl/instr_queue_ctrl.sv
// iq_ctrl: head/tail/occupancy bookkeeping; full/empty come from the count, never from pointer compare
module iq_ctrl #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq_valid,
  input  logic          deq_ready,
  output logic          enq_ready,
  output logic          deq_valid,
  output logic          wr_en,
  output logic [PW-1:0] wr_idx,
  output logic [PW-1:0] rd_idx,
  output logic [CW-1:0] count
);
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          w_enq_fire, w_deq_fire;
  assign enq_ready  = r_count != CW'(DEPTH);
  assign deq_valid  = r_count != '0;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;
  assign wr_en      = w_enq_fire & ~flush;
  assign wr_idx     = r_tail;
  assign rd_idx     = r_head;
  assign count      = r_count;
  // pointer and occupancy update; flush wins over any same-cycle enqueue/dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) r_tail <= r_tail + 1'b1;
      if (w_deq_fire) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_enq_fire) - CW'(w_deq_fire);
    end
  end
endmodule

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-issue FIFO of {ir, pc, is_cf} with masked head outputs
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq_valid,
  input  lc3b_word      enq_ir,
  input  lc3b_word      enq_pc,
  output logic          enq_ready,
  output logic          deq_valid,
  output lc3b_word      deq_ir,
  output lc3b_word      deq_pc,
  output lc3b_opcode    deq_opcode,
  output logic          deq_is_cf,
  input  logic          deq_ready,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  iq_entry_t     r_mem [DEPTH];
  iq_entry_t     w_head;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx, w_rd_idx;
  iq_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .deq_ready (deq_ready),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .wr_en     (w_wr_en),
    .wr_idx    (w_wr_idx),
    .rd_idx    (w_rd_idx),
    .count     (count)
  );
  // entry storage is never cleared; stale data is hidden by deq_valid masking
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= '{ir: enq_ir, pc: enq_pc, is_cf: is_control_flow(enq_ir[15:12])};
  end
  assign w_head     = deq_valid ? r_mem[w_rd_idx] : '0;
  assign deq_ir     = w_head.ir;
  assign deq_pc     = w_head.pc;
  assign deq_opcode = w_head.ir[15:12];
  assign deq_is_cf  = w_head.is_cf;
endmodule
